// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared prescale constants, default widths and majority vote for the UART RX front end.
package uart_rx_pkg;
  localparam int PRESCALE_W_DEF = 6;
  localparam int BIT_CNT_W_DEF = 4;
  localparam int PRESCALE_8 = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/rx_oversampler_if.sv
// rx_oversampler_if: serial line, prescale and RX FSM sequencing signals around the oversampler.
interface rx_oversampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W = 4
);
  logic RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic sampled_bit;
  logic sample_valid;
  modport master (
    output RX_IN, Prescale, samp_en,
    input edge_cnt, bit_cnt, sampled_bit, sample_valid
  );
  modport slave (
    input RX_IN, Prescale, samp_en,
    output edge_cnt, bit_cnt, sampled_bit, sample_valid
  );
endinterface

// File: rtl/rx_edge_bit_counter.sv
// rx_edge_bit_counter: edge/bit counters within a frame, cleared while samp_en is low.
module rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_CNT_W = BIT_CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic [PRESCALE_W-1:0] p_eff
);
  logic wrap;
  always_comb begin
    p_eff = (prescale == PRESCALE_W'(PRESCALE_16) || prescale == PRESCALE_W'(PRESCALE_32)) ? prescale : PRESCALE_W'(PRESCALE_8);
    // >= rather than == so a mid-frame shrink of P wraps at once instead of running the counter round
    wrap = edge_cnt >= p_eff - PRESCALE_W'(1);
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
    end else if (!samp_en) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      edge_cnt <= wrap ? '0 : edge_cnt + PRESCALE_W'(1);
      if (wrap && bit_cnt != '1) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
endmodule

// File: rtl/rx_oversampler.sv
// rx_oversampler: UART RX front end, 3-sample majority vote around mid-bit, one strobe per bit period.
// Define RX_OVERSAMPLER_SYNC_EN to pass RX_IN through a 2-flop synchronizer first.
module rx_oversampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_CNT_W = BIT_CNT_W_DEF
) (
  input logic CLK,
  input logic RST,
  rx_oversampler_if.slave bus
);
  logic [PRESCALE_W-1:0] p_eff, mid, mid_m1, mid_p1;
  logic rx_s, s0, s1;
  rx_edge_bit_counter #(.PRESCALE_W(PRESCALE_W), .BIT_CNT_W(BIT_CNT_W)) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .samp_en(bus.samp_en),
    .prescale(bus.Prescale),
    .edge_cnt(bus.edge_cnt),
    .bit_cnt(bus.bit_cnt),
    .p_eff(p_eff)
  );
`ifdef RX_OVERSAMPLER_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) sync <= 2'b11;
    else sync <= {sync[0], bus.RX_IN};
  assign rx_s = sync[1];
`else
  assign rx_s = bus.RX_IN;
`endif
  always_comb begin
    mid = p_eff >> 1;
    mid_m1 = mid - PRESCALE_W'(1);
    mid_p1 = mid + PRESCALE_W'(1);
  end
  // s2 is the live line value at mid+1, so the vote lands one cycle later at mid+2
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      bus.sampled_bit <= 1'b1;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= bus.samp_en && bus.edge_cnt == mid_p1;
      if (!bus.samp_en) begin
        s0 <= 1'b0;
        s1 <= 1'b0;
      end else begin
        if (bus.edge_cnt == mid_m1) s0 <= rx_s;
        if (bus.edge_cnt == mid) s1 <= rx_s;
        if (bus.edge_cnt == mid_p1) bus.sampled_bit <= maj3(s0, s1, rx_s);
      end
    end
endmodule

// File: tb/tb_rx_oversampler.sv
// tb_rx_oversampler: directed checks of counting, voting, enable clear, async reset and prescale fallback.
module tb_rx_oversampler;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int checks = 0;
  int errors = 0;
  int e = 0;
  int b = 0;
  rx_oversampler_if bus ();
  rx_oversampler dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int p, input int n, input logic [31:0] pat, input int vpos, input logic exp_bit);
    for (int i = 0; i < n; i++) begin
      bus.RX_IN = pat[e];
      tick();
      e = (e == p - 1) ? 0 : e + 1;
      if (e == 0 && b != 15) b++;
      chk("edge_cnt", bus.edge_cnt, 32'(e));
      chk("bit_cnt", bus.bit_cnt, 32'(b));
      chk("sample_valid", bus.sample_valid, 32'(e == vpos));
      if (e == vpos) chk("sampled_bit", bus.sampled_bit, 32'(exp_bit));
    end
  endtask
  task automatic disable_en(input logic exp_bit);
    bus.samp_en = 1'b0;
    tick();
    chk("clr_edge", bus.edge_cnt, 0);
    chk("clr_bit", bus.bit_cnt, 0);
    chk("clr_valid", bus.sample_valid, 0);
    chk("clr_hold", bus.sampled_bit, 32'(exp_bit));
    e = 0;
    b = 0;
  endtask
  initial begin
    bus.RX_IN = 1'b1;
    bus.Prescale = 6'd8;
    bus.samp_en = 1'b0;
    repeat (3) tick();
    chk("rst_edge", bus.edge_cnt, 0);
    chk("rst_bit", bus.bit_cnt, 0);
    chk("rst_sampled", bus.sampled_bit, 1);
    chk("rst_valid", bus.sample_valid, 0);
    RST = 1'b1;
    tick();
    // P=8, line held low for two periods
    bus.samp_en = 1'b1;
    run(8, 16, 32'h0, 6, 1'b0);
    chk("p8_bitcnt2", bus.bit_cnt, 2);
    run(8, 8, 32'hFFFF_FFFF, 6, 1'b1);
    run(8, 8, 32'h10, 6, 1'b0);
    run(8, 8, 32'h28, 6, 1'b1);
    run(8, 8, 32'h20, 6, 1'b0);
    run(8, 8, 32'h18, 6, 1'b1);
    run(8, 8, 32'h08, 6, 1'b0);
    // P=16: high at 7 and 9, low at 8
    disable_en(1'b0);
    bus.Prescale = 6'd16;
    bus.samp_en = 1'b1;
    run(16, 16, 32'h280, 10, 1'b1);
    // P=32, 20 periods: bit_cnt saturates at 15
    disable_en(1'b1);
    bus.Prescale = 6'd32;
    bus.samp_en = 1'b1;
    run(32, 640, 32'h0, 18, 1'b0);
    chk("p32_sat", bus.bit_cnt, 15);
    // drop samp_en in the s2 cycle: clear wins, bit holds
    disable_en(1'b0);
    bus.Prescale = 6'd16;
    bus.samp_en = 1'b1;
    run(16, 9, 32'hFFFF_FFFF, 10, 1'b1);
    chk("pre_drop_edge", bus.edge_cnt, 9);
    disable_en(1'b0);
    tick();
    chk("drop_no_valid", bus.sample_valid, 0);
    chk("drop_hold", bus.sampled_bit, 0);
    bus.samp_en = 1'b1;
    run(16, 16, 32'hFFFF_FFFF, 10, 1'b1);
    // async reset mid-frame at edge_cnt=5
    disable_en(1'b1);
    bus.Prescale = 6'd8;
    bus.samp_en = 1'b1;
    run(8, 8, 32'h0, 6, 1'b0);
    run(8, 5, 32'h0, 6, 1'b0);
    chk("pre_rst_edge", bus.edge_cnt, 5);
    chk("pre_rst_bit", bus.bit_cnt, 1);
    #2 RST = 1'b0;
    #1;
    chk("arst_edge", bus.edge_cnt, 0);
    chk("arst_bit", bus.bit_cnt, 0);
    chk("arst_sampled", bus.sampled_bit, 1);
    chk("arst_valid", bus.sample_valid, 0);
    tick();
    RST = 1'b1;
    e = 0;
    b = 0;
    run(8, 16, 32'h0, 6, 1'b0);
    // illegal Prescale=12 falls back to P=8
    disable_en(1'b0);
    bus.Prescale = 6'd12;
    bus.samp_en = 1'b1;
    run(8, 16, 32'h38, 6, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_oversampler.md
Name: rx_oversampler

Overview:
- UART receive front end: oversamples the serial line at the prescale rate and produces one majority-voted bit per bit period.
- Sits directly upstream of the start-check, parity-check, stop-check and deserializer stages, which consume sampled_bit on the cycle sample_valid is high.
- Also exports the edge and bit counters that the RX FSM uses to sequence those stages.
- Replaces the separate edge counter and sampler pair with one block.

Parameters:
- PRESCALE_W, 6: width of Prescale input and edge_cnt output.
- BIT_CNT_W, 4: width of bit_cnt output.

Ports:
- CLK  in  1  oversampling clock (Prescale x baud)
- RST  in  1  asynchronous active-low reset
- RX_IN  in  1  serial line, idle high
- Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- samp_en  in  1  from RX FSM; high for the whole frame
- edge_cnt  out  PRESCALE_W  position within current bit period
- bit_cnt  out  BIT_CNT_W  number of completed bit periods in frame
- sampled_bit  out  1  majority-voted value of latest bit
- sample_valid  out  1  one-cycle strobe: sampled_bit updated

Behaviour:
- Reset: edge_cnt=0, bit_cnt=0, sampled_bit=1 (idle level), sample_valid=0, internal sample regs=0. Reset is asynchronous; it aborts any frame in progress with no residue.
- Effective prescale P: Prescale if 8/16/32, else 8. P is resampled every cycle; Prescale is held static while samp_en=1, and a change mid-frame is undefined but must not lock up.
- mid = P/2.
- samp_en=0: edge_cnt and bit_cnt forced to 0 next cycle; sample regs cleared; sample_valid=0; sampled_bit holds its last value.
- samp_en=1: edge_cnt increments each cycle. At edge_cnt==P-1 it wraps to 0 and bit_cnt increments. bit_cnt saturates at all-ones.
- Sampling: RX_IN is captured in the cycles where edge_cnt == mid-1 (s0) and mid (s1).
- In the cycle edge_cnt == mid+1, the current RX_IN is s2. On that clock edge, sampled_bit <= majority(s0,s1,s2) and sample_valid <= 1.
- Therefore sample_valid is high exactly in the cycle edge_cnt == mid+2, once per bit period. Latency from s2 to output is one cycle.
- Majority: result 1 iff at least 2 of 3 samples are 1. A single-sample glitch is rejected.
- samp_en deasserted in the same cycle as the s2 edge: the clear wins. No sample_valid is produced and sampled_bit holds.
- samp_en re-asserted: counting restarts at edge_cnt=0. No stale samples are used.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: RX_OVERSAMPLER_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (reset value 1) before sampling. The sample point shifts 2 CLK cycles after the line; counter-relative timing is unchanged.
- Not defined: RX_IN is sampled directly, for a line that is already synchronous.

Decomposition:
- Shared package (uart_rx_pkg) holds:
  - prescale constants PRESCALE_8/16/32;
  - default widths;
  - the majority-of-3 function.
- Natural sub-module: rx_edge_bit_counter, containing the edge_cnt/bit_cnt logic, the enable clear and the P selection.
- Sampling and voting stay in the top module.

Test Plan:
- P=8, samp_en=1, RX_IN=0 held: sample_valid high when edge_cnt=6 each period; sampled_bit=0; bit_cnt 0->1 after 8 cycles.
- P=8, RX_IN=0 except 1 in the cycle edge_cnt=4: sampled_bit=0 (glitch rejected).
- P=16, RX_IN=1 during edge_cnt 7 and 9, 0 at 8: sampled_bit=1, sample_valid at edge_cnt=10.
- P=32, 20 full periods: edge_cnt wraps 31->0, bit_cnt saturates at 15, sample_valid at edge_cnt=18 each period.
- samp_en dropped at edge_cnt=9 (P=16): no sample_valid, counters 0 next cycle, sampled_bit unchanged. Re-enable restarts from edge_cnt=0.
- RST asserted mid-frame at edge_cnt=5: all outputs at reset values immediately (asynchronous). Operation resumes cleanly after release.
- Prescale=12: behaves as P=8.
